// File: rtl/button_debouncer.sv
// Push-button conditioner: a 2+ flop synchroniser followed by a stability-qualifying
// FSM that outputs a registered clean level plus single-cycle rise/fall pulses.
module button_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic level_nx, rise_nx, fall_nx, busy_nx;

  // Synchroniser shift chain; only its last stage is ever seen by the FSM.
  logic [SYNC_STAGES-1:0] sync;
  logic s;
  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], btn_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE_LOW;
      cnt        <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      level_out  <= level_nx;
      rise_pulse <= rise_nx;
      fall_pulse <= fall_nx;
      busy       <= busy_nx;
    end
  end

  // Any reversal during a WAIT state drops back to idle with the count cleared.
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (s) begin
          state_nx = WAIT_HIGH;
          cnt_nx   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_nx = IDLE_LOW;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE_HIGH;
          rise_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_nx = WAIT_LOW;
          cnt_nx   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_nx = IDLE_HIGH;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE_LOW;
          fall_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: state_nx = IDLE_LOW;
    endcase
    level_nx = (state_nx == IDLE_HIGH) || (state_nx == WAIT_LOW);
    busy_nx  = (state_nx == WAIT_HIGH) || (state_nx == WAIT_LOW);
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer at default parameters (2 sync stages,
// 4 stable samples): latency, glitch rejection, bounce, fall, reset, long hold.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic level_out, rise_pulse, fall_pulse, busy;

  int checks = 0;
  int errors = 0;

  button_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e,
                           input logic lv, input logic rp, input logic fp, input logic bz);
    check($sformatf("%s e%0d level", tag, e), level_out, lv);
    check($sformatf("%s e%0d rise", tag, e), rise_pulse, rp);
    check($sformatf("%s e%0d fall", tag, e), fall_pulse, fp);
    check($sformatf("%s e%0d busy", tag, e), busy, bz);
  endtask

  int rises, falls, both;

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;
    tick();
    tick();
    check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (4) tick();
    check_all("idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // T1: clean press, rise at edge 6, busy edges 3-5
    btn_in = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check_all("T1", e, (e >= 6), (e == 6), 1'b0, (e >= 3 && e <= 5));
    end

    // T4: clean release from high, fall at edge 6
    btn_in = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check_all("T4", e, (e < 6), 1'b0, (e == 6), (e >= 3 && e <= 5));
    end

    // T2: 3-cycle pulse is rejected; busy only while qualifying
    btn_in = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) btn_in = 1'b0;
      check_all("T2", e, 1'b0, 1'b0, 1'b0, (e >= 3 && e <= 5));
    end

    // T3: bounce 1,0,1,0,1 then solid 1; last 0->1 reaches s at edge 6, rise at 10
    for (int e = 1; e <= 20; e++) begin
      btn_in = (e == 2 || e == 4) ? 1'b0 : 1'b1;
      tick();
      check_all("T3", e, (e >= 10), (e == 10), 1'b0,
                (e == 3 || e == 5 || (e >= 7 && e <= 9)));
    end

    btn_in = 1'b0;
    repeat (12) tick();
    check_all("T5pre", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // T5: reset mid-WAIT_HIGH with button held; re-qualifies 6 edges after release
    btn_in = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check_all("T5a", e, 1'b0, 1'b0, 1'b0, (e >= 3));
    end
    rst = 1'b1;
    tick();
    check_all("T5rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check_all("T5b", e, (e >= 6), (e == 6), 1'b0, (e >= 3 && e <= 5));
    end

    // Reset during the rise pulse drops level and pulse at that edge
    btn_in = 1'b0;
    repeat (12) tick();
    btn_in = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_all("rstpulse", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    btn_in = 1'b0;
    repeat (12) tick();
    check_all("T6pre", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // T6: 100-cycle hold gives exactly one rise, no fall, never both
    rises = 0; falls = 0; both = 0;
    btn_in = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      tick();
      if (rise_pulse === 1'b1) rises++;
      if (fall_pulse === 1'b1) falls++;
      if (rise_pulse === 1'b1 && fall_pulse === 1'b1) both++;
    end
    check_int("T6 rises", rises, 1);
    check_int("T6 falls", falls, 0);
    check_int("T6 both", both, 0);
    check("T6 level", level_out, 1'b1);
    check("T6 busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
